shape_draw_sequencer: RTL and testbench

- Parametrised successor to the game's draw controller: time-multiplexes NUM_SHAPES shape drawer modules onto the single VGA adapter write port.
- Each frame pass draws, in order: the clear shape, one selected frame of the player animation, then every static shape that is enabled by its mask bit.
- Adds a one-deep frame-tick queue, sticky overrun detection, per-shape enable masking, a parametrised animation length, and a final-clear-then-disable sequence when the game stops.

---
 rtl/shape_draw_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_shape_draw_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_draw_sequencer.sv
// shape_draw_sequencer
// Time-multiplexes NUM_SHAPES shape drawers onto one VGA write port. Each
// pass draws the clear shape, one player animation frame, then every enabled
// static shape. Frame ticks are queued one deep, ticks that land mid-pass
// raise a sticky overrun flag, and dropping run performs a final clear
// before the adapter is disabled.
module shape_draw_sequencer #(
  parameter int NUM_SHAPES  = 18,
  parameter int ANIM_FRAMES = 7,
  parameter int COORD_W     = 11,
  parameter int COLOUR_W    = 3,
  parameter int ID_W        = 5
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           run,
  input  logic                           jump_n,
  input  logic                           frame_tick,
  input  logic [NUM_SHAPES-1:0]          shape_mask,
  input  logic [NUM_SHAPES-1:0]          draw_done,
  input  logic [NUM_SHAPES*COORD_W-1:0]  shape_x,
  input  logic [NUM_SHAPES*COORD_W-1:0]  shape_y,
  input  logic [NUM_SHAPES*COLOUR_W-1:0] shape_colour,
  output logic [NUM_SHAPES-1:0]          draw_start,
  output logic [NUM_SHAPES-1:0]          shape_reset,
  output logic                           vga_enable,
  output logic [COORD_W-1:0]             out_x,
  output logic [COORD_W-1:0]             out_y,
  output logic [COLOUR_W-1:0]            out_colour,
  output logic [ID_W-1:0]                curr_id,
  output logic                           busy,
  output logic                           overrun
);

  localparam logic [ID_W-1:0]       CLEAR_ID   = ID_W'(NUM_SHAPES - 1);
  localparam logic [ID_W-1:0]       IDLE_FRAME = ID_W'(ANIM_FRAMES - 1);
  localparam logic [ID_W-1:0]       LAST_STEP  = ID_W'(ANIM_FRAMES - 2);
  localparam logic [NUM_SHAPES-1:0] ONE_BIT    = NUM_SHAPES'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_START,
    S_WAIT,
    S_NEXT,
    S_FCLEAR_START,
    S_FCLEAR_WAIT
  } state_t;

  state_t                  state, state_next;
  logic [NUM_SHAPES-1:0]   draw_start_next;
  logic [NUM_SHAPES-1:0]   shape_reset_next;
  logic                    vga_enable_next;
  logic [ID_W-1:0]         curr_id_next;
  logic                    overrun_next;
  logic                    tick_pending, tick_pending_next;
  logic                    jump_pending, jump_pending_next;
  logic                    jumping, jumping_next;
  logic [ID_W-1:0]         anim_step, anim_step_next;
  logic [ID_W-1:0]         pass_frame, pass_frame_next;

  // Unpacked views of the packed per-shape buses
  logic [COORD_W-1:0]      x_arr   [NUM_SHAPES];
  logic [COORD_W-1:0]      y_arr   [NUM_SHAPES];
  logic [COLOUR_W-1:0]     col_arr [NUM_SHAPES];
  // Static shapes that are enabled and come after the current id
  logic [NUM_SHAPES-1:0]   cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SHAPES; gi++) begin : g_shape
      assign x_arr[gi]   = shape_x[gi*COORD_W +: COORD_W];
      assign y_arr[gi]   = shape_y[gi*COORD_W +: COORD_W];
      assign col_arr[gi] = shape_colour[gi*COLOUR_W +: COLOUR_W];
      if (gi >= ANIM_FRAMES && gi < NUM_SHAPES - 1) begin : g_static
        assign cand[gi] = shape_mask[gi] && (ID_W'(gi) > curr_id);
      end else begin : g_fixed
        assign cand[gi] = 1'b0;
      end
    end
  endgenerate

  assign out_x      = x_arr[curr_id];
  assign out_y      = y_arr[curr_id];
  assign out_colour = col_arr[curr_id];

  logic done_sel;
  assign done_sel = draw_done[curr_id];

  assign busy = (state == S_START) || (state == S_WAIT) || (state == S_NEXT) ||
                (state == S_FCLEAR_START) || (state == S_FCLEAR_WAIT);

  // Lowest enabled static shape above curr_id (scan from the top down)
  logic            static_found;
  logic [ID_W-1:0] static_id;
  always_comb begin
    static_found = 1'b0;
    static_id    = CLEAR_ID;
    for (int j = NUM_SHAPES - 2; j >= ANIM_FRAMES; j--) begin
      if (cand[j]) begin
        static_found = 1'b1;
        static_id    = ID_W'(j);
      end
    end
  end

  // Successor in the pass order: clear -> animation frame -> static shapes
  logic            next_valid;
  logic [ID_W-1:0] next_id;
  always_comb begin
    next_valid = static_found;
    next_id    = static_id;
    if (curr_id == CLEAR_ID) begin
      next_valid = 1'b1;
      next_id    = pass_frame;
    end
  end

  // Frame for a pass starting now; a pending jump starts at step 0
  logic [ID_W-1:0] frame_now;
  always_comb begin
    if (jumping) begin
      frame_now = anim_step;
    end else if (jump_pending) begin
      frame_now = '0;
    end else begin
      frame_now = IDLE_FRAME;
    end
  end

  // Next-state and register-update logic for the whole sequencer
  always_comb begin
    state_next        = state;
    draw_start_next   = draw_start;
    shape_reset_next  = shape_reset;
    vga_enable_next   = vga_enable;
    curr_id_next      = curr_id;
    overrun_next      = overrun;
    tick_pending_next = tick_pending;
    jump_pending_next = jump_pending;
    jumping_next      = jumping;
    anim_step_next    = anim_step;
    pass_frame_next   = pass_frame;

    // Input events; state transitions below take precedence
    if (!jump_n && run && !jumping) begin
      jump_pending_next = 1'b1;
    end
    if (frame_tick && busy) begin
      tick_pending_next = 1'b1;
      // A tick coinciding with the normal end of a pass is just queued
      if (!(state == S_NEXT && !next_valid && run)) begin
        overrun_next = 1'b1;
      end
    end

    case (state)
      S_OFF: begin
        if (run) begin
          state_next       = S_IDLE;
          shape_reset_next = '0;
          vga_enable_next  = 1'b1;
        end
      end

      S_IDLE, S_START, S_WAIT, S_NEXT: begin
        if (!run) begin
          draw_start_next = '0;
          curr_id_next    = CLEAR_ID;
          state_next      = S_FCLEAR_START;
        end else begin
          case (state)
            S_IDLE: begin
              if (frame_tick || tick_pending) begin
                tick_pending_next = 1'b0;
                curr_id_next      = CLEAR_ID;
                pass_frame_next   = frame_now;
                state_next        = S_START;
                if (!jumping && jump_pending) begin
                  jumping_next      = 1'b1;
                  anim_step_next    = '0;
                  jump_pending_next = 1'b0;
                end
              end
            end
            S_START: begin
              draw_start_next = ONE_BIT << curr_id;
              state_next      = S_WAIT;
            end
            S_WAIT: begin
              if (done_sel) begin
                draw_start_next = '0;
                state_next      = S_NEXT;
              end
            end
            default: begin  // S_NEXT
              if (next_valid) begin
                // Raise the next request here so NEXT is the only idle cycle
                curr_id_next    = next_id;
                draw_start_next = ONE_BIT << next_id;
                state_next      = S_START;
              end else begin
                state_next = S_IDLE;
                if (jumping) begin
                  if (anim_step == LAST_STEP) begin
                    jumping_next   = 1'b0;
                    anim_step_next = '0;
                  end else begin
                    anim_step_next = anim_step + ID_W'(1);
                  end
                end
              end
            end
          endcase
        end
      end

      S_FCLEAR_START: begin
        draw_start_next = ONE_BIT << CLEAR_ID;
        state_next      = S_FCLEAR_WAIT;
      end

      S_FCLEAR_WAIT: begin
        if (done_sel) begin
          draw_start_next   = '0;
          vga_enable_next   = 1'b0;
          shape_reset_next  = '1;
          jumping_next      = 1'b0;
          jump_pending_next = 1'b0;
          tick_pending_next = 1'b0;
          state_next        = S_OFF;
        end
      end

      default: begin
        state_next = S_OFF;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_OFF;
      draw_start   <= '0;
      shape_reset  <= '1;
      vga_enable   <= 1'b0;
      curr_id      <= CLEAR_ID;
      overrun      <= 1'b0;
      tick_pending <= 1'b0;
      jump_pending <= 1'b0;
      jumping      <= 1'b0;
      anim_step    <= '0;
      pass_frame   <= IDLE_FRAME;
    end else begin
      state        <= state_next;
      draw_start   <= draw_start_next;
      shape_reset  <= shape_reset_next;
      vga_enable   <= vga_enable_next;
      curr_id      <= curr_id_next;
      overrun      <= overrun_next;
      tick_pending <= tick_pending_next;
      jump_pending <= jump_pending_next;
      jumping      <= jumping_next;
      anim_step    <= anim_step_next;
      pass_frame   <= pass_frame_next;
    end
  end

endmodule

// File: tb/tb_shape_draw_sequencer.sv
// tb_shape_draw_sequencer
// Directed bench: a table of frame passes (mask, jump press, expected frame,
// expected shape count) plus hand-written sequences for latency, tick queueing,
// overrun, the stop sequence and asynchronous reset.
module tb_shape_draw_sequencer;

  localparam int NS = 18;
  localparam int AF = 7;
  localparam int CW = 11;
  localparam int KW = 3;
  localparam int IW = 5;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b0;
  logic          jump_n = 1'b1;
  logic          frame_tick = 1'b0;
  logic [NS-1:0] shape_mask = '1;
  logic [NS-1:0] draw_done;
  logic [NS*CW-1:0] shape_x;
  logic [NS*CW-1:0] shape_y;
  logic [NS*KW-1:0] shape_colour;
  logic [NS-1:0] draw_start;
  logic [NS-1:0] shape_reset;
  logic          vga_enable;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic [KW-1:0] out_colour;
  logic [IW-1:0] curr_id;
  logic          busy;
  logic          overrun;

  always #5 clock = ~clock;

  shape_draw_sequencer #(
    .NUM_SHAPES(NS), .ANIM_FRAMES(AF), .COORD_W(CW), .COLOUR_W(KW), .ID_W(IW)
  ) dut (
    .clock(clock), .resetn(resetn), .run(run), .jump_n(jump_n),
    .frame_tick(frame_tick), .shape_mask(shape_mask), .draw_done(draw_done),
    .shape_x(shape_x), .shape_y(shape_y), .shape_colour(shape_colour),
    .draw_start(draw_start), .shape_reset(shape_reset), .vga_enable(vga_enable),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .curr_id(curr_id),
    .busy(busy), .overrun(overrun)
  );

  // Drawer model: done rises 3 cycles after start, falls when start drops
  int cnt [NS];
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NS; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NS; i++)
        cnt[i] <= draw_start[i] ? ((cnt[i] < 15) ? cnt[i] + 1 : cnt[i]) : 0;
    end
  end
  always_comb begin
    draw_done = '0;
    for (int i = 0; i < NS; i++) draw_done[i] = (cnt[i] >= 3);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: records each new draw request, the idle cycles before it,
  // one-hot violations and the coordinate mux against known shape data
  int            seq_q [$];
  int            gap_q [$];
  int            low_cnt = 0;
  int            onehot_err = 0;
  int            mux_err = 0;
  int            mux_n = 0;
  logic [NS-1:0] prev_ds = '0;
  always @(negedge clock) begin
    int id;
    id = 0;
    if ($countones(draw_start) > 1) onehot_err++;
    if (draw_start != '0) begin
      for (int i = 0; i < NS; i++) if (draw_start[i]) id = i;
      mux_n++;
      if (out_x != CW'(100 + 7*id) || out_y != CW'(50 + 3*id) || out_colour != KW'(id))
        mux_err++;
      if (draw_start != prev_ds) begin
        seq_q.push_back(id);
        gap_q.push_back(low_cnt);
        low_cnt = 0;
      end
    end else if (busy) begin
      low_cnt++;
    end
    prev_ds = draw_start;
  end

  task automatic pulse_tick();
    @(posedge clock); #1 frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input string name);
    int c;
    c = 0;
    while (busy !== val && c < 400) begin
      @(negedge clock);
      c++;
    end
    check(name, int'(c < 400), 1);
  endtask

  task automatic wait_ds_bit(input int b, input string name);
    int c;
    c = 0;
    while (draw_start[b] !== 1'b1 && c < 400) begin
      @(negedge clock);
      c++;
    end
    check(name, int'(c < 400), 1);
  endtask

  task automatic wait_ds_zero(input string name);
    int c;
    c = 0;
    while (draw_start !== '0 && c < 400) begin
      @(negedge clock);
      c++;
    end
    check(name, int'(c < 400), 1);
  endtask

  typedef struct {
    logic [NS-1:0] mask;
    bit            press;
    int            exp_frame;
    int            exp_count;
  } vec_t;

  vec_t vecs [10];

  // One full pass: optional jump press, tick, then compare the draw order
  task automatic run_pass(input vec_t v, input int idx);
    int exp_q [$];
    int n;
    shape_mask = v.mask;
    @(negedge clock);
    seq_q.delete();
    gap_q.delete();
    if (v.press) begin
      @(posedge clock); #1 jump_n = 1'b0;
      @(posedge clock); #1 jump_n = 1'b1;
    end
    pulse_tick();
    wait_busy(1'b1, $sformatf("v%0d_busy_rise", idx));
    wait_busy(1'b0, $sformatf("v%0d_busy_fall", idx));
    @(negedge clock);
    exp_q.push_back(NS - 1);
    exp_q.push_back(v.exp_frame);
    for (int j = AF; j < NS - 1; j++) if (v.mask[j]) exp_q.push_back(j);
    check($sformatf("v%0d_len", idx), seq_q.size(), v.exp_count);
    n = (seq_q.size() < exp_q.size()) ? seq_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("v%0d_id%0d", idx, k), seq_q[k], exp_q[k]);
      if (k > 0) check($sformatf("v%0d_gap%0d", idx, k), gap_q[k], 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      shape_x[i*CW +: CW]      = CW'(100 + 7*i);
      shape_y[i*CW +: CW]      = CW'(50 + 3*i);
      shape_colour[i*KW +: KW] = KW'(i);
    end
    vecs[0] = '{18'h3FFFF, 1'b0, 6, 12};
    vecs[1] = '{18'h3DDFF, 1'b0, 6, 10};
    vecs[2] = '{18'h3FFFF, 1'b1, 0, 12};
    vecs[3] = '{18'h3FFFF, 1'b0, 1, 12};
    vecs[4] = '{18'h3FFFF, 1'b1, 2, 12};
    vecs[5] = '{18'h3FFFF, 1'b0, 3, 12};
    vecs[6] = '{18'h3FFFF, 1'b0, 4, 12};
    vecs[7] = '{18'h3FFFF, 1'b0, 5, 12};
    vecs[8] = '{18'h3FFFF, 1'b0, 6, 12};
    vecs[9] = '{18'h10080, 1'b0, 6, 4};

    // Reset state
    @(negedge clock);
    check("rst_draw_start", int'(draw_start), 0);
    check("rst_shape_reset", int'(shape_reset), 32'h3FFFF);
    check("rst_vga_enable", int'(vga_enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_curr_id", int'(curr_id), 17);

    // OFF -> IDLE on run
    @(posedge clock); #1 resetn = 1'b1; run = 1'b1;
    @(negedge clock);
    check("off_vga_before_edge", int'(vga_enable), 0);
    @(negedge clock);
    check("idle_vga_enable", int'(vga_enable), 1);
    check("idle_shape_reset", int'(shape_reset), 0);

    // Tick-to-start latency: START cycle low, then draw_start[17]
    shape_mask = '1;
    pulse_tick();
    @(negedge clock);
    check("lat_start_cycle_ds", int'(draw_start), 0);
    check("lat_start_busy", int'(busy), 1);
    @(negedge clock);
    check("lat_ds17", int'(draw_start[17]), 1);
    wait_busy(1'b0, "lat_pass_end");

    // Table-driven passes
    for (int v = 0; v < 10; v++) run_pass(vecs[v], v);

    // Tick in the cycle the pass ends: queued, no overrun
    shape_mask = '0;
    pulse_tick();
    wait_ds_bit(6, "edge_wait_ds6");
    wait_ds_zero("edge_wait_next");
    frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    @(negedge clock);
    check("edge_idle_busy", int'(busy), 0);
    @(negedge clock);
    check("edge_restart_busy", int'(busy), 1);
    check("edge_no_overrun", int'(overrun), 0);
    wait_busy(1'b0, "edge_pass_end");

    // Tick mid-pass: sticky overrun, immediate restart, single queued pass
    shape_mask = '1;
    pulse_tick();
    repeat (10) @(negedge clock);
    check("ovr_before", int'(overrun), 0);
    frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    @(negedge clock);
    check("ovr_set", int'(overrun), 1);
    wait_busy(1'b0, "ovr_first_end");
    @(negedge clock);
    check("ovr_restart", int'(busy), 1);
    wait_busy(1'b0, "ovr_second_end");
    repeat (5) @(negedge clock);
    check("ovr_no_third", int'(busy), 0);
    check("ovr_sticky", int'(overrun), 1);

    // Stop while shape 10 is waiting
    pulse_tick();
    wait_ds_bit(10, "stop_wait_ds10");
    @(negedge clock);
    check("stop_ds10_in_wait", int'(draw_start[10]), 1);
    check("stop_vga_before", int'(vga_enable), 1);
    run = 1'b0;
    @(negedge clock);
    check("stop_abort_ds", int'(draw_start), 0);
    check("stop_curr_id", int'(curr_id), 17);
    wait_ds_bit(17, "stop_clear_start");
    wait_ds_zero("stop_clear_done");
    check("stop_vga_off", int'(vga_enable), 0);
    check("stop_shape_reset", int'(shape_reset), 32'h3FFFF);
    check("stop_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a WAIT
    run = 1'b1;
    @(negedge clock);
    pulse_tick();
    wait_ds_bit(17, "arst_wait_ds17");
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("arst_draw_start", int'(draw_start), 0);
    check("arst_vga_enable", int'(vga_enable), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_shape_reset", int'(shape_reset), 32'h3FFFF);
    check("arst_overrun", int'(overrun), 0);
    @(posedge clock); #1 resetn = 1'b1; run = 1'b0;
    @(negedge clock);

    check("mon_onehot_violations", onehot_err, 0);
    check("mon_mux_errors", mux_err, 0);
    check("mon_mux_sampled", int'(mux_n > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
